// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the SEQ memory stage (master) and the data memory (slave).
// The master holds mem_req until a one-cycle mem_ack; mem_rdata and mem_err are valid with mem_ack.
interface mem_access_stage_if #(
  parameter int ADDR_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_ack;
  logic              mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack, mem_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// SEQ memory stage: data reads/writes over a req/ack bus, valM capture and sticky address error.
// Optional ack timeout is enabled with the MEM_ACCESS_TIMEOUT_EN macro.
//
// state  | meaning
// IDLE   | waiting for start; start is decoded and latched here only
// ACCESS | mem_req held with latched we/addr/wdata until ack (or timeout)
// DONE   | one-cycle done pulse, then back to IDLE
module mem_access_stage #(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 8192,
  parameter int MAX_WAIT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [3:0]          icode_i,
  input  logic [63:0]         vale_i,
  input  logic [63:0]         vala_i,
  input  logic [63:0]         valp_i,
  mem_access_stage_if.master  mem_bus,
  output logic [63:0]         valm_o,
  output logic                done_o,
  output logic                busy_o,
  output logic                dmem_error_o
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       valm_q, valm_d;
  logic              err_q, err_d;

  logic              is_rd, is_wr, addr_ok;
  logic [63:0]       sel_addr, sel_wdata;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    is_rd     = (icode_i == I_MRMOVQ) || (icode_i == I_POPQ) || (icode_i == I_RET);
    is_wr     = (icode_i == I_RMMOVQ) || (icode_i == I_PUSHQ) || (icode_i == I_CALL);
    sel_addr  = ((icode_i == I_POPQ) || (icode_i == I_RET)) ? vala_i : vale_i;
    sel_wdata = (icode_i == I_CALL) ? valp_i : vala_i;
    // Full-width unsigned compare, so addresses near 2^64 never wrap into range.
    addr_ok   = (sel_addr <= ADDR_MAX);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valm_d  = valm_q;
    err_d   = err_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if ((is_rd || is_wr) && addr_ok) begin
            state_d = ACCESS;
            we_d    = is_wr;
            addr_d  = sel_addr[ADDR_W-1:0];
            wdata_d = sel_wdata;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_d   = CNT_W'(MAX_WAIT - 1);
`endif
          end else begin
            state_d = DONE;
            if (is_rd || is_wr) err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_bus.mem_ack) begin
          state_d = DONE;
          if (mem_bus.mem_err) err_d = 1'b1;
          else if (!we_q)      valm_d = mem_bus.mem_rdata;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valm_q  <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mem_bus.mem_req   = (state_q == ACCESS);
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;
  assign valm_o            = valm_q;
  assign done_o            = (state_q == DONE);
  // Busy covers the start cycle itself, before the FSM has left IDLE.
  assign busy_o            = (state_q != IDLE) || start_i;
  assign dmem_error_o      = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; drives and samples on the falling edge.
// Build with MEM_ACCESS_TIMEOUT_EN defined to exercise the ack timeout path.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] vale, vala, valp;
  logic [63:0] valm;
  logic        done, busy, dmem_error;

  int n_cmp = 0;
  int n_mis = 0;

  mem_access_stage_if #(.ADDR_W(64)) mbus ();

  mem_access_stage #(.ADDR_W(64), .MEM_BYTES(8192), .MAX_WAIT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .icode_i      (icode),
    .vale_i       (vale),
    .vala_i       (vala),
    .valp_i       (valp),
    .mem_bus      (mbus),
    .valm_o       (valm),
    .done_o       (done),
    .busy_o       (busy),
    .dmem_error_o (dmem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents start for one cycle; returns at the falling edge of cycle t+1.
  task automatic issue(input string nm, input logic [3:0] ic, input logic [63:0] ve, va, vp);
    start = 1'b1; icode = ic; vale = ve; vala = va; valp = vp;
    #1 chk({nm, "_busy_start"}, 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full memory transaction: ack arrives dly cycles after mem_req rises.
  task automatic run_mem(input string nm, input logic [3:0] ic, input logic [63:0] ve, va, vp,
                         input logic exp_we, input logic [63:0] exp_addr, exp_wdata,
                         input int dly, input logic [63:0] rd, input logic er);
    issue(nm, ic, ve, va, vp);
    chk({nm, "_req"},  64'(mbus.mem_req), 64'd1);
    chk({nm, "_we"},   64'(mbus.mem_we), 64'(exp_we));
    chk({nm, "_addr"}, mbus.mem_addr, exp_addr);
    if (exp_we) chk({nm, "_wdata"}, mbus.mem_wdata, exp_wdata);
    repeat (dly) @(negedge clk);
    chk({nm, "_req_held"},  64'(mbus.mem_req), 64'd1);
    chk({nm, "_addr_held"}, mbus.mem_addr, exp_addr);
    chk({nm, "_no_early_done"}, 64'(done), 64'd0);
    mbus.mem_ack = 1'b1; mbus.mem_rdata = rd; mbus.mem_err = er;
    @(negedge clk);
    mbus.mem_ack = 1'b0; mbus.mem_err = 1'b0; mbus.mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    chk({nm, "_done"},     64'(done), 64'd1);
    chk({nm, "_req_drop"}, 64'(mbus.mem_req), 64'd0);
    chk({nm, "_busy_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({nm, "_done_once"}, 64'(done), 64'd0);
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  // No-access path: done one cycle after start, no request.
  task automatic run_nomem(input string nm, input logic [3:0] ic, input logic [63:0] ve, va, vp,
                           input logic exp_err);
    issue(nm, ic, ve, va, vp);
    chk({nm, "_noreq"}, 64'(mbus.mem_req), 64'd0);
    chk({nm, "_done"},  64'(done), 64'd1);
    chk({nm, "_err"},   64'(dmem_error), 64'(exp_err));
    @(negedge clk);
    chk({nm, "_done_once"}, 64'(done), 64'd0);
    chk({nm, "_noreq2"}, 64'(mbus.mem_req), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; icode = 4'h0; vale = '0; vala = '0; valp = '0;
    mbus.mem_ack = 1'b0; mbus.mem_err = 1'b0; mbus.mem_rdata = '0;
    @(negedge clk);
    do_reset();

    chk("rst_req",  64'(mbus.mem_req), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valm", valm, 64'd0);
    chk("rst_err",  64'(dmem_error), 64'd0);

    run_mem("mrmovq", 4'h5, 64'h100, 64'h0, 64'h0, 1'b0, 64'h100, 64'h0, 3, 64'hDEAD_BEEF, 1'b0);
    chk("mrmovq_valm", valm, 64'hDEAD_BEEF);
    chk("mrmovq_err",  64'(dmem_error), 64'd0);

    run_mem("call", 4'h8, 64'h1F8, 64'h77, 64'h40, 1'b1, 64'h1F8, 64'h40, 1, 64'h1111, 1'b0);
    chk("call_valm_kept", valm, 64'hDEAD_BEEF);

    run_mem("rmmovq", 4'h4, 64'h300, 64'hABCD, 64'h99, 1'b1, 64'h300, 64'hABCD, 0, 64'h2222, 1'b0);
    chk("rmmovq_valm_kept", valm, 64'hDEAD_BEEF);

    run_mem("popq", 4'hB, 64'h208, 64'h200, 64'h0, 1'b0, 64'h200, 64'h0, 2, 64'hCAFE_F00D, 1'b0);
    chk("popq_valm", valm, 64'hCAFE_F00D);

    run_mem("ret", 4'h9, 64'h10, 64'h1FF8, 64'h0, 1'b0, 64'h1FF8, 64'h0, 1, 64'h0123_4567_89AB_CDEF, 1'b0);
    chk("ret_valm", valm, 64'h0123_4567_89AB_CDEF);

    run_mem("pushq_edge", 4'hA, 64'h1FF8, 64'h55, 64'h0, 1'b1, 64'h1FF8, 64'h55, 1, 64'h0, 1'b0);
    chk("pushq_err", 64'(dmem_error), 64'd0);

    run_nomem("opq", 4'h6, 64'h100, 64'h100, 64'h100, 1'b0);

    // Stray ack while idle must not touch valM.
    mbus.mem_ack = 1'b1; mbus.mem_rdata = 64'hBAD0;
    @(negedge clk);
    mbus.mem_ack = 1'b0;
    chk("idle_ack_valm", valm, 64'h0123_4567_89AB_CDEF);
    chk("idle_ack_done", 64'(done), 64'd0);

    // Start during ACCESS is ignored.
    issue("busy_start", 4'h5, 64'h400, 64'h0, 64'h0);
    start = 1'b1; icode = 4'h8; vale = 64'h800; valp = 64'h1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_addr", mbus.mem_addr, 64'h400);
    chk("busy_start_we",   64'(mbus.mem_we), 64'd0);
    mbus.mem_ack = 1'b1; mbus.mem_rdata = 64'h4444;
    @(negedge clk);
    mbus.mem_ack = 1'b0;
    chk("busy_start_valm", valm, 64'h4444);
    @(negedge clk);
    chk("busy_start_noreq", 64'(mbus.mem_req), 64'd0);
    chk("busy_start_idle",  64'(busy), 64'd0);

    run_nomem("rmmovq_ill", 4'h4, 64'd8185, 64'h1, 64'h0, 1'b1);
    run_nomem("popq_wrap", 4'hB, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b1);
    run_mem("after_err", 4'h5, 64'h20, 64'h0, 64'h0, 1'b0, 64'h20, 64'h0, 1, 64'h7777, 1'b0);
    chk("after_err_valm", valm, 64'h7777);
    chk("after_err_sticky", 64'(dmem_error), 64'd1);

    // Reset in the middle of an access, then a late ack.
    issue("rst_mid", 4'h5, 64'h100, 64'h0, 64'h0);
    chk("rst_mid_req", 64'(mbus.mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_req_drop", 64'(mbus.mem_req), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_valm", valm, 64'd0);
    chk("rst_mid_err",  64'(dmem_error), 64'd0);
    mbus.mem_ack = 1'b1; mbus.mem_rdata = 64'h9999;
    @(negedge clk);
    mbus.mem_ack = 1'b0;
    chk("late_ack_done", 64'(done), 64'd0);
    chk("late_ack_valm", valm, 64'd0);
    chk("late_ack_req",  64'(mbus.mem_req), 64'd0);

    // Faulted read: error set, valM unchanged.
    run_mem("memerr", 4'h5, 64'h100, 64'h0, 64'h0, 1'b0, 64'h100, 64'h0, 1, 64'h1234, 1'b1);
    chk("memerr_valm", valm, 64'd0);
    chk("memerr_err",  64'(dmem_error), 64'd1);

    do_reset();
    begin
      int req_cycles;
      req_cycles = 0;
      issue("tmo", 4'h5, 64'h100, 64'h0, 64'h0);
      while (mbus.mem_req && req_cycles < 40) begin
        req_cycles++;
        @(negedge clk);
      end
`ifdef MEM_ACCESS_TIMEOUT_EN
      chk("tmo_req_cycles", 64'(req_cycles), 64'd16);
      chk("tmo_done", 64'(done), 64'd1);
      chk("tmo_err",  64'(dmem_error), 64'd1);
      chk("tmo_valm", valm, 64'd0);
      @(negedge clk);
      chk("tmo_done_once", 64'(done), 64'd0);
`else
      chk("notmo_req_cycles", 64'(req_cycles), 64'd40);
      chk("notmo_req_held", 64'(mbus.mem_req), 64'd1);
      chk("notmo_err", 64'(dmem_error), 64'd0);
      mbus.mem_ack = 1'b1; mbus.mem_rdata = 64'h6161;
      @(negedge clk);
      mbus.mem_ack = 1'b0;
      chk("notmo_done", 64'(done), 64'd1);
      chk("notmo_valm", valm, 64'h6161);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- SEQ memory stage: sits between execute and write_back.
- Produces valM for write_back (mrmovq, popq, ret) and performs data writes (rmmovq, pushq, call).
- Drives an external data memory over a req/ack handshake.
- Reports done/busy to the sequencer and a sticky dmem_error for status (SADR).

Parameters:
- ADDR_W, 64, width of mem_addr.
- MEM_BYTES, 8192, size of the addressable data region; legal 8-byte access iff addr <= MEM_BYTES-8.
- MAX_WAIT, 16, ack timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: execute results valid this cycle.
- icode  in  4  instruction code.
- valE  in  64  ALU result.
- valA  in  64  register A value.
- valP  in  64  next PC.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  ADDR_W  byte address; stable while mem_req.
- mem_wdata  out  64  write data; stable while mem_req.
- mem_rdata  in  64  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- mem_err  in  1  valid with mem_ack; access faulted.
- valM  out  64  read result to write_back.
- done  out  1  one-cycle pulse: stage complete.
- busy  out  1  high from the start cycle until the done cycle, inclusive.
- dmem_error  out  1  sticky error flag.

Behaviour:
- Reset: all outputs are 0; FSM goes to IDLE. rst has priority over everything. Reset mid-access drops mem_req on the next edge; a late mem_ack is ignored.
- Decode, latched on start:
  - Address = valE for rmmovq(4), mrmovq(5), pushq(A), call(8).
  - Address = valA for popq(B), ret(9).
  - Write data = valA for rmmovq/pushq; valP for call.
  - Reads: mrmovq, popq, ret. Writes: rmmovq, pushq, call. All other icodes: no access.
- FSM:
  - IDLE -> ACCESS on start with a legal memory op.
  - IDLE -> DONE on start with a non-memory op or an illegal address. An illegal address sets dmem_error; no request is issued.
  - ACCESS: mem_req=1; mem_we/mem_addr/mem_wdata come from latched values. On mem_ack -> DONE. On a read ack, capture valM=mem_rdata. mem_err=1 sets dmem_error, and valM is left unchanged.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- start while busy is ignored; no latch occurs.
- Latency:
  - Non-memory op: start at cycle t -> done at t+1.
  - Memory op: mem_req rises at t+1; ack at cycle t+k -> done at t+k+1. valM is valid from t+k+1 and holds until the next read completes.
- mem_req deasserts the cycle after ack. mem_ack while not in ACCESS is ignored.
- dmem_error: cleared only by rst. Setting dmem_error does not block later accesses.
- Address check: full 64-bit unsigned compare against MEM_BYTES-8, with no wrap. 0xFFFF_FFFF_FFFF_FFF8 is illegal.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined: a cycle counter runs in ACCESS and resets on entry. If no ack arrives by MAX_WAIT cycles, the stage drops mem_req, sets dmem_error and goes to DONE; valM is unchanged.
- Undefined: no counter is present, and ACCESS waits indefinitely.

Test Plan:
- mrmovq, valE=0x100, ack with rdata=0xDEADBEEF 3 cycles after req -> mem_addr=0x100, mem_we=0; valM=0xDEADBEEF; done pulses once, 1 cycle after ack; dmem_error=0.
- call, valE=0x1F8, valP=0x40 -> write req with addr=0x1F8, wdata=0x40; valM unchanged.
- popq, valA=0x200, valE=0x208 -> mem_addr=0x200 (valA, not valE); read data appears on valM.
- opq icode=6 -> no mem_req; done at start+1.
- rmmovq, valE=MEM_BYTES-7 -> no req; dmem_error=1; done at start+1. A subsequent legal read completes normally and dmem_error stays 1.
- rst asserted mid-ACCESS, followed by a late ack -> mem_req=0, busy=0, valM=0, no done. With MEM_ACCESS_TIMEOUT_EN and no ack -> mem_req drops after MAX_WAIT=16 cycles, dmem_error=1, done pulses.
